audio_dac_tx: RTL

- Playback-side counterpart of the microphone capture path: accepts 8-bit audio samples on a valid/ready stream and buffers them in a small FIFO.
- On every sample-rate tick, emits one 16-bit SPI write frame to a 12-bit serial DAC (DAC121S101-class).
- Sits between the audio processing datapath and the DAC pins.
- Clocked from the 100 MHz system clock; default output rate is 20 kHz.

---
 rtl/audio_dac_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_tx
// Description : Buffers 8-bit audio samples and sends one 16-bit SPI write
//               frame to a 12-bit serial DAC on every sample-rate tick.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_tx #(
    parameter int SAMPLE_DIV = 5000,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_cs,
    output logic       busy,
    output logic       underrun,
    output logic       frame_done
);
    localparam int c_rate_w = $clog2(SAMPLE_DIV);
    localparam int c_div_w  = $clog2(CLK_DIV + 1);
    localparam int c_addr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_rate_w-1:0] c_rate_last = c_rate_w'(SAMPLE_DIV - 1);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_addr_w:0]   c_full_cnt  = (c_addr_w + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_low   = 3'd2;
    localparam logic [2:0] c_st_high  = 3'd3;
    localparam logic [2:0] c_st_end   = 3'd4;

    logic [c_rate_w-1:0] r_rate;
    logic                w_tick;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr;
    logic [c_addr_w-1:0] r_rd;
    logic [c_addr_w:0]   r_count;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          r_last;
    logic [7:0]          w_word;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic                w_accept;
    logic [c_div_w-1:0]  r_div;
    logic                w_div_end;
    logic [3:0]          r_bit;
    logic [15:0]         r_shift;
    logic [15:0]         w_shift_nxt;
    logic                w_cs_nxt;
    logic                w_sclk_nxt;
    logic                w_mosi_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // Free-running sample-rate counter
    assign w_tick = (r_rate == c_rate_last);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_rate <= '0;
        end else begin
            r_rate <= r_rate + 1'b1;
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full_cnt);
    assign in_ready = !w_full;
    assign w_accept = w_tick && (r_state == c_st_idle);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = w_accept && !w_empty;
    assign underrun = w_accept && w_empty;
    assign w_word   = w_empty ? r_last : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= 8'h80;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= r_mem[r_rd];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_div_end = (r_div == c_div_last);

    // State register; SPI pins are flopped from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_div      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            spi_cs     <= 1'b1;
            spi_clk    <= 1'b1;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift_nxt;
            if ((w_next != r_state) || (r_state == c_st_idle)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (r_state == c_st_idle) begin
                r_bit <= '0;
            end else if ((r_state == c_st_high) && w_div_end) begin
                r_bit <= r_bit + 1'b1;
            end
            spi_cs     <= w_cs_nxt;
            spi_clk    <= w_sclk_nxt;
            spi_mosi   <= w_mosi_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_tick)    w_next = c_st_setup;
            c_st_setup: if (w_div_end) w_next = c_st_low;
            c_st_low:   if (w_div_end) w_next = c_st_high;
            c_st_high:  if (w_div_end) w_next = (r_bit == 4'd15) ? c_st_end : c_st_low;
            c_st_end:   if (w_div_end) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    // Data shifts on HIGH entry so MOSI launches on the rising SPI edge
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = {4'b0000, w_word, 4'b0000};
        end else if ((r_state == c_st_low) && w_div_end) begin
            w_shift_nxt = {r_shift[14:0], 1'b0};
        end
        w_cs_nxt   = !(w_next inside {c_st_setup, c_st_low, c_st_high});
        w_sclk_nxt = (w_next != c_st_low);
        w_mosi_nxt = w_cs_nxt ? 1'b0 : w_shift_nxt[15];
        w_busy_nxt = (w_next != c_st_idle);
        w_done_nxt = (r_state == c_st_end) && w_div_end;
    end

endmodule
`default_nettype wire
